// File: rtl/zxbus_mux_slave_if.sv
// rtl/zxbus_mux_slave_if.sv - ZX-bus front-end signal bundle
// Purpose: groups the Z80 strobes, the FCI mux pins, the captured cycle
// attributes and the per-channel device handshake into one bundle.
// Ports (signals):
//   rd, wr, mrq, iorq   Z80 strobes, active-high, asynchronous to clk
//   fci_in[7:0]         FCI mux data selected by fci_sel
//   fci_sel[1:0]        0=ZA[7:0] 1=ZA[15:8] 2=ZD[7:0]
//   fci_dir             1=bus released (input), 0=drive fci_dout
//   fci_dout[7:0]       read data returned to the Z80
//   zaddr, zdata_in     captured address / write data
//   zxb_rnw, zxb_mni    1=read cycle, 1=memory cycle
//   ch_en, ch_req, ch_stb, ch_rdata   per-channel decode/request/strobe/data
// Modports: slave = the front end, master = the Z80/device side.
interface zxbus_mux_slave_if #(
    parameter int N_CH = 4
);
    logic              rd;
    logic              wr;
    logic              mrq;
    logic              iorq;
    logic [7:0]        fci_in;
    logic [1:0]        fci_sel;
    logic              fci_dir;
    logic [7:0]        fci_dout;
    logic [15:0]       zaddr;
    logic [7:0]        zdata_in;
    logic              zxb_rnw;
    logic              zxb_mni;
    logic [N_CH-1:0]   ch_en;
    logic [N_CH-1:0]   ch_req;
    logic [N_CH-1:0]   ch_stb;
    logic [8*N_CH-1:0] ch_rdata;

    modport slave (
        input  rd, wr, mrq, iorq, fci_in, ch_en, ch_stb, ch_rdata,
        output fci_sel, fci_dir, fci_dout, zaddr, zdata_in, zxb_rnw, zxb_mni, ch_req
    );

    modport master (
        output rd, wr, mrq, iorq, fci_in, ch_en, ch_stb, ch_rdata,
        input  fci_sel, fci_dir, fci_dout, zaddr, zdata_in, zxb_rnw, zxb_mni, ch_req
    );
endinterface

// File: rtl/zxbus_mux_slave.sv
// rtl/zxbus_mux_slave.sv - ZX-bus slave front end with FCI mux capture and channel arbitration
// Purpose: resynchronises the Z80 strobes, walks the FCI mux to capture
// ZA[15:0]/ZD[7:0], grants the cycle to the lowest decoded channel with a
// req/stb handshake (optional timeout) and returns read data to the Z80.
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   bus          zxbus_mux_slave_if.slave (Z80, FCI and channel signals)
//   busy         high in every state except INIT/IDLE
//   timeout_err  one-cycle pulse when a handshake is aborted
module zxbus_mux_slave #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE      = 1,
    parameter int TIMEOUT     = 64
) (
    input  logic                    clk,
    input  logic                    reset_n,
    zxbus_mux_slave_if.slave        bus,
    output logic                    busy,
    output logic                    timeout_err
);
    localparam int GW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_SET_H, S_ADDR_H, S_SET_D, S_DECODE, S_WAIT, S_FINISH
    } state_t;

    // Strobe combinations: bit0=mrd bit1=mwr bit2=ird bit3=iwr
    logic [3:0]                    strobes;
    logic [SYNC_STAGES-1:0][3:0]   sync_q;
    logic                          s_mrd, s_mwr, s_ird, act;

    assign strobes = {bus.iorq & bus.wr, bus.iorq & bus.rd, bus.mrq & bus.wr, bus.mrq & bus.rd};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= strobes;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s_mrd = sync_q[SYNC_STAGES-1][0];
    assign s_mwr = sync_q[SYNC_STAGES-1][1];
    assign s_ird = sync_q[SYNC_STAGES-1][2];
    assign act   = |sync_q[SYNC_STAGES-1];

    state_t            state_q, state_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [GW-1:0]     grant_q, grant_d, grant_idx;
    logic [1:0]        sel_q, sel_d;
    logic              dir_q, dir_d;
    logic [7:0]        dout_q, dout_d;
    logic [15:0]       zaddr_q, zaddr_d;
    logic [7:0]        zdata_q, zdata_d;
    logic              rnw_q, rnw_d, mni_q, mni_d;
    logic [N_CH-1:0]   req_q, req_d;
    logic              terr_q, terr_d;
    logic              settle_done, tmo_hit, stb_g;
    logic [7:0]        rdata_g;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_INIT;
            settle_q <= '0;
            tmo_q    <= '0;
            grant_q  <= '0;
            sel_q    <= 2'd0;
            dir_q    <= 1'b1;
            dout_q   <= 8'hFF;
            zaddr_q  <= '0;
            zdata_q  <= '0;
            rnw_q    <= 1'b0;
            mni_q    <= 1'b0;
            req_q    <= '0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            tmo_q    <= tmo_d;
            grant_q  <= grant_d;
            sel_q    <= sel_d;
            dir_q    <= dir_d;
            dout_q   <= dout_d;
            zaddr_q  <= zaddr_d;
            zdata_q  <= zdata_d;
            rnw_q    <= rnw_d;
            mni_q    <= mni_d;
            req_q    <= req_d;
            terr_q   <= terr_d;
        end
    end

    // Settle states always occupy at least one cycle; with SETTLE=0 the
    // SET_H/SET_D states are skipped altogether.
    assign settle_done = (SETTLE == 0) || (settle_q == SW'(SETTLE - 1));
    assign tmo_hit     = (TIMEOUT != 0) && (tmo_q == TW'(TIMEOUT - 1));
    assign stb_g       = bus.ch_stb[grant_q];
    assign rdata_g     = bus.ch_rdata[{grant_q, 3'b000} +: 8];

    // Lowest-index decode hit wins.
    always_comb begin
        grant_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (bus.ch_en[i]) grant_idx = GW'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        tmo_d    = tmo_q;
        grant_d  = grant_q;
        sel_d    = sel_q;
        dir_d    = dir_q;
        dout_d   = dout_q;
        zaddr_d  = zaddr_q;
        zdata_d  = zdata_q;
        rnw_d    = rnw_q;
        mni_d    = mni_q;
        req_d    = req_q;
        terr_d   = 1'b0;
        case (state_q)
            S_INIT: begin
                sel_d = 2'd0;
                if (settle_done) begin
                    settle_d = '0;
                    state_d  = S_IDLE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            S_IDLE: begin
                zaddr_d[7:0] = bus.fci_in;
                if (act) begin
                    rnw_d    = s_mrd | s_ird;
                    mni_d    = s_mrd | s_mwr;
                    sel_d    = 2'd1;
                    settle_d = '0;
                    state_d  = (SETTLE == 0) ? S_ADDR_H : S_SET_H;
                end
            end
            S_SET_H: begin
                if (settle_done) begin
                    settle_d = '0;
                    state_d  = S_ADDR_H;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            S_ADDR_H: begin
                zaddr_d[15:8] = bus.fci_in;
                sel_d         = 2'd2;
                settle_d      = '0;
                state_d       = (SETTLE == 0) ? S_DECODE : S_SET_D;
            end
            S_SET_D: begin
                if (settle_done) begin
                    settle_d = '0;
                    state_d  = S_DECODE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            S_DECODE: begin
                tmo_d = '0;
                if (!(|bus.ch_en)) begin
                    state_d = S_FINISH;
                end else begin
                    grant_d            = grant_idx;
                    req_d              = '0;
                    req_d[grant_idx]   = 1'b1;
                    if (rnw_q) begin
                        dir_d  = 1'b0;
                        dout_d = 8'hFF;
                    end else begin
                        zdata_d = bus.fci_in;
                    end
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Strobe is tested first so it wins on the timeout cycle.
                if (stb_g) begin
                    req_d = '0;
                    if (rnw_q) dout_d = rdata_g;
                    state_d = S_FINISH;
                end else if (tmo_hit) begin
                    req_d   = '0;
                    terr_d  = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_FINISH: begin
                if (!act) begin
                    dir_d    = 1'b1;
                    sel_d    = 2'd0;
                    settle_d = '0;
                    state_d  = S_INIT;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    assign bus.fci_sel  = sel_q;
    assign bus.fci_dir  = dir_q;
    assign bus.fci_dout = dout_q;
    assign bus.zaddr    = zaddr_q;
    assign bus.zdata_in = zdata_q;
    assign bus.zxb_rnw  = rnw_q;
    assign bus.zxb_mni  = mni_q;
    assign bus.ch_req   = req_q;
    assign busy         = (state_q != S_INIT) && (state_q != S_IDLE);
    assign timeout_err  = terr_q;
endmodule

// File: tb/tb_zxbus_mux_slave.sv
// tb/tb_zxbus_mux_slave.sv - directed scoreboard bench for zxbus_mux_slave
module tb_zxbus_mux_slave;
    localparam int N_CH = 4;
    localparam int TMO  = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        busy, timeout_err;
    logic [15:0] za = 16'h0000;
    logic [7:0]  zd = 8'h00;
    logic [7:0]  rd_tab [4] = '{8'h96, 8'h5A, 8'hA5, 8'h3C};

    zxbus_mux_slave_if #(.N_CH(N_CH)) bus();

    zxbus_mux_slave #(.N_CH(N_CH), .SYNC_STAGES(2), .SETTLE(1), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Board-level FCI mux
    assign bus.fci_in = (bus.fci_sel == 2'd0) ? za[7:0] :
                        (bus.fci_sel == 2'd1) ? za[15:8] : zd;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic        rnw;
        logic        mni;
        logic [3:0]  req;
        logic [7:0]  dout;
        logic        dir_wait;
        int          hi;
        logic        terr;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input bit rd_cyc, input bit mem, input logic [15:0] a,
                                   input logic [7:0] d, input logic [3:0] en, input int sd);
        exp_t e;
        int g = -1;
        bit done;
        for (int i = 3; i >= 0; i--) if (en[i]) g = i;
        done       = (sd >= 0) && (sd < TMO);
        e.a        = a;
        e.d        = d;
        e.rnw      = rd_cyc;
        e.mni      = mem;
        e.req      = (g >= 0) ? 4'(1 << g) : 4'd0;
        e.dir_wait = !((g >= 0) && rd_cyc);
        e.hi       = (g < 0) ? 0 : (done ? sd + 1 : TMO);
        e.terr     = (g >= 0) && !done;
        e.dout     = ((g >= 0) && rd_cyc && done) ? rd_tab[g] : 8'hFF;
        return e;
    endfunction

    // One Z80 cycle: sd = delay of granted-channel stb in WAIT cycles (-1 none),
    // nd/nch = a stray stb on a non-granted channel (nd=-1 none).
    task automatic z80_cycle(input bit rd_cyc, input bit mem, input logic [15:0] a,
                             input logic [7:0] d, input logic [3:0] en,
                             input int sd, input int nd, input int nch);
        exp_t e;
        int k, hi, tc;
        repeat (3) @(negedge clk);
        za = a; zd = d; bus.ch_en = en;
        sb.push_back(model(rd_cyc, mem, a, d, en, sd));
        bus.mrq = mem; bus.iorq = !mem; bus.rd = rd_cyc; bus.wr = !rd_cyc;
        k = 0;
        while (bus.ch_req == 4'd0 && k < 12) begin
            @(negedge clk);
            k++;
        end
        e = sb.pop_front();
        chk("req_first", bus.ch_req, e.req);
        if (e.req != 4'd0) chk("req_latency", k, 7);
        chk("zaddr", bus.zaddr, e.a);
        chk("rnw", bus.zxb_rnw, e.rnw);
        chk("mni", bus.zxb_mni, e.mni);
        chk("busy_active", busy, 1'b1);
        chk("dir_active", bus.fci_dir, e.dir_wait);
        if (e.req != 4'd0 && !rd_cyc) chk("zdata_in", bus.zdata_in, e.d);
        if (e.req != 4'd0 && rd_cyc) chk("dout_wait", bus.fci_dout, 8'hFF);
        hi = 0; tc = 0; k = 0;
        while (bus.ch_req != 4'd0 && k < 40) begin
            hi++;
            chk("req_hold", bus.ch_req, e.req);
            chk("dir_hold", bus.fci_dir, e.dir_wait);
            bus.ch_stb = ((k == sd) ? e.req : 4'd0) | ((k == nd) ? 4'(1 << nch) : 4'd0);
            @(posedge clk);
            @(negedge clk);
            if (timeout_err) tc++;
            k++;
        end
        bus.ch_stb = 4'd0;
        chk("req_cycles", hi, e.hi);
        chk("terr_pulse", tc, e.terr);
        chk("req_dropped", bus.ch_req, 4'd0);
        if (e.req != 4'd0 && rd_cyc) chk("dout_final", bus.fci_dout, e.dout);
        @(negedge clk);
        chk("terr_width", timeout_err, 1'b0);
        chk("dir_until_drop", bus.fci_dir, e.dir_wait);
        bus.mrq = 1'b0; bus.iorq = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0;
        k = 0;
        while (busy && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("back_to_init", busy, 1'b0);
        chk("dir_released", bus.fci_dir, 1'b1);
        chk("sel_reset", bus.fci_sel, 2'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int k;
        bus.rd = 1'b0; bus.wr = 1'b0; bus.mrq = 1'b0; bus.iorq = 1'b0;
        bus.ch_en = 4'd0; bus.ch_stb = 4'd0;
        bus.ch_rdata = {rd_tab[3], rd_tab[2], rd_tab[1], rd_tab[0]};
        za = 16'h1234;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sel", bus.fci_sel, 2'd0);
        chk("rst_dir", bus.fci_dir, 1'b1);
        chk("rst_dout", bus.fci_dout, 8'hFF);
        chk("rst_zaddr", bus.zaddr, 16'h0000);
        chk("rst_zdata", bus.zdata_in, 8'h00);
        chk("rst_rnw", bus.zxb_rnw, 1'b0);
        chk("rst_mni", bus.zxb_mni, 1'b0);
        chk("rst_req", bus.ch_req, 4'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_terr", timeout_err, 1'b0);
        reset_n = 1'b1;

        // Memory read, ch2 completes after 3 clocks
        z80_cycle(1'b1, 1'b1, 16'h5B00, 8'h00, 4'b0100, 3, -1, 0);
        // I/O write, two hits -> ch0; stray stb on ch1 ignored
        z80_cycle(1'b0, 1'b0, 16'h00FE, 8'h07, 4'b0011, 1, 0, 1);
        // No decode hit, read and write
        z80_cycle(1'b1, 1'b0, 16'h1F3B, 8'h00, 4'b0000, -1, -1, 0);
        z80_cycle(1'b0, 1'b1, 16'hC0DE, 8'h55, 4'b0000, -1, -1, 0);
        // Timeout on read with no stb
        z80_cycle(1'b1, 1'b1, 16'h8000, 8'h00, 4'b1000, -1, -1, 0);
        // Stb exactly on the timeout cycle, stray stb on ch2 earlier
        z80_cycle(1'b1, 1'b0, 16'h7FFD, 8'h00, 4'b0110, TMO - 1, 3, 2);

        // Reset while waiting for a channel
        repeat (3) @(negedge clk);
        za = 16'h4321; bus.ch_en = 4'b0001;
        sb.push_back(model(1'b1, 1'b1, 16'h4321, 8'h00, 4'b0001, -1));
        bus.mrq = 1'b1; bus.rd = 1'b1;
        k = 0;
        while (bus.ch_req == 4'd0 && k < 12) begin
            @(negedge clk);
            k++;
        end
        e = sb.pop_front();
        chk("mid_req", bus.ch_req, e.req);
        chk("mid_zaddr", bus.zaddr, e.a);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_req", bus.ch_req, 4'd0);
        chk("mid_rst_dir", bus.fci_dir, 1'b1);
        chk("mid_rst_dout", bus.fci_dout, 8'hFF);
        chk("mid_rst_busy", busy, 1'b0);
        bus.mrq = 1'b0; bus.rd = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        z80_cycle(1'b0, 1'b1, 16'hABCD, 8'hE1, 4'b1000, 0, -1, 0);
        z80_cycle(1'b1, 1'b1, 16'h0A0B, 8'h00, 4'b1010, 2, 1, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
